// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: ops, HI/LO select, FSM states.
package mdu_pkg;
    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = $clog2(MDU_WIDTH);

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    localparam logic [1:0] RHL_LO = 2'b00;
    localparam logic [1:0] RHL_HI = 2'b01;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_FIN  = 2'b10
    } mdu_state_e;
endpackage

// File: rtl/mdu_if.sv
// Request / HI-LO bus between ID-stage decode and the multiply/divide unit.
interface mdu_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             rhl_wr;
    logic [1:0]       rhl_sel;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, flush, rhl_wr, rhl_sel, wdata,
                    input  busy, done, hi, lo);
    modport slave  (input  start, op, a, b, flush, rhl_wr, rhl_sel, wdata,
                    output busy, done, hi, lo);
endinterface

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH-1:0] diff;
    logic             fits;

    assign sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    assign shl  = {acc_hi, acc_lo[WIDTH-1]};
    assign fits = (shl >= {1'b0, m});
    // Remainder stays below m, so the difference always fits in WIDTH bits.
    assign diff = shl[WIDTH-1:0] - m;

    always_comb begin
        nxt_hi = sum[WIDTH:1];
        nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        if (div_mode) begin
            nxt_hi = fits ? diff : shl[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], fits};
        end
    end
endmodule

// File: rtl/mul_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// MDU_SINGLE_CYCLE_MUL_EN: multiplies go IDLE->FIN through a full-width multiplier.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic  clk,
    input  logic  rst,
    mdu_if.slave  bus
);
    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mdu_state_e       state, nxt_state;
    logic             is_div_q, neg_q, neg_r;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] m_q, acc_hi, acc_lo, step_hi, step_lo, hi_q, lo_q;
    logic [WIDTH-1:0] a_mag, b_mag, res_hi, res_lo;
    logic [2*WIDTH-1:0] raw, prod;
    logic             sa, sb, accept, fast_mul;

    assign sa     = bus.op[0] & bus.a[WIDTH-1];
    assign sb     = bus.op[0] & bus.b[WIDTH-1];
    assign a_mag  = sa ? -bus.a : bus.a;
    assign b_mag  = sb ? -bus.b : bus.b;
    // A coincident flush cancels the request outright.
    assign accept = (state == MDU_IDLE) && bus.start && !bus.flush;

`ifdef MDU_SINGLE_CYCLE_MUL_EN
    assign fast_mul = !bus.op[1];
    assign raw      = is_div_q ? {acc_hi, acc_lo}
                               : {{WIDTH{1'b0}}, m_q} * {{WIDTH{1'b0}}, acc_lo};
`else
    assign fast_mul = 1'b0;
    assign raw      = {acc_hi, acc_lo};
`endif

    assign prod   = neg_q ? -raw : raw;
    assign res_hi = is_div_q ? (neg_r ? -acc_hi : acc_hi) : prod[2*WIDTH-1:WIDTH];
    assign res_lo = is_div_q ? (neg_q ? -acc_lo : acc_lo) : prod[WIDTH-1:0];

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (is_div_q),
        .acc_hi   (acc_hi),
        .acc_lo   (acc_lo),
        .m        (m_q),
        .nxt_hi   (step_hi),
        .nxt_lo   (step_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MDU_IDLE;
        else     state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            MDU_IDLE: if (accept) nxt_state = fast_mul ? MDU_FIN : MDU_CALC;
            MDU_CALC: begin
                if (bus.flush)             nxt_state = MDU_IDLE;
                else if (cnt == CNT_LAST)  nxt_state = MDU_FIN;
            end
            MDU_FIN:  nxt_state = MDU_IDLE;
            default:  nxt_state = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            cnt      <= '0;
            m_q      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (accept) begin
                        is_div_q <= bus.op[1];
                        neg_q    <= sa ^ sb;
                        neg_r    <= sa;
                        cnt      <= '0;
                        acc_hi   <= '0;
                        // Divide shifts the dividend through acc_lo; multiply shifts the multiplier.
                        acc_lo   <= bus.op[1] ? a_mag : b_mag;
                        m_q      <= bus.op[1] ? b_mag : a_mag;
                    end else if (bus.rhl_wr && !bus.start) begin
                        if (bus.rhl_sel == RHL_HI)      hi_q <= bus.wdata;
                        else if (bus.rhl_sel == RHL_LO) lo_q <= bus.wdata;
                    end
                end
                MDU_CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + CNT_W'(1);
                end
                MDU_FIN: begin
                    if (!bus.flush) begin
                        hi_q <= res_hi;
                        lo_q <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != MDU_IDLE);
    assign bus.done = (state == MDU_FIN) && !bus.flush;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
